// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the F/D/E/M/W hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    VBUSY = 1'b1
  } hz_state_t;

  localparam int VEC_LAT_DEF = 4;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side hazard signals; HAZARD_PERF_EN adds the stall/flush counters.
interface pipeline_hazard_ctrl_if #(
  parameter int RA_W = 3
);
  logic [RA_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [RA_W-1:0] WA3E, WA3M, WA3W;
  logic            RegWriteE, RegWriteM, RegWriteW;
  logic            MemtoRegE, BranchTakenE, VecStartE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            VecBusy, VecDone;
`ifdef HAZARD_PERF_EN
  logic [15:0]     StallCnt, FlushCnt;
`endif

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, VecStartE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, VecBusy, VecDone
`ifdef HAZARD_PERF_EN
    , input StallCnt, FlushCnt
`endif
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, VecStartE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, VecBusy, VecDone
`ifdef HAZARD_PERF_EN
    , output StallCnt, FlushCnt
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_vec_busy_counter.sv
// RUN/VBUSY sequencer: holds VBUSY for VEC_LAT-1 cycles after a vector start.
module vec_busy_counter
  import hazard_pkg::*;
#(
  parameter int VEC_LAT = VEC_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        if (start) begin
          state_nxt = VBUSY;
          cnt_nxt   = CNT_W'(VEC_LAT - 1);
        end
      end
      VBUSY: begin
        busy    = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          done      = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stalls, branch flushes, vector-op hold.
// Optional counters StallCnt/FlushCnt are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int VEC_LAT = VEC_LAT_DEF,
  parameter int RA_W    = 3
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  function automatic fwd_sel_t fwd_pick(input logic wem, input logic [RA_W-1:0] wam,
                                        input logic wew, input logic [RA_W-1:0] waw,
                                        input logic [RA_W-1:0] ra);
    if (wem && (wam == ra)) return FWD_M;
    if (wew && (waw == ra)) return FWD_W;
    return FWD_RF;
  endfunction

  logic     busy, done, start, ldstall;
  fwd_sel_t fwd_a, fwd_b;

  // A branch squashes the vector op in E, so it never starts the sequencer.
  assign start = hz.VecStartE & ~hz.BranchTakenE;

  vec_busy_counter #(.VEC_LAT(VEC_LAT)) u_vec (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done)
  );

  assign ldstall = hz.MemtoRegE & hz.RegWriteE &
                   ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));

  assign fwd_a = fwd_pick(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA1E);
  assign fwd_b = fwd_pick(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA2E);

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.ForwardAE = FWD_RF;
    hz.ForwardBE = FWD_RF;
    hz.VecBusy   = 1'b0;
    hz.VecDone   = 1'b0;
    if (reset) begin
      hz.ForwardAE = fwd_a;
      hz.ForwardBE = fwd_b;
      hz.VecBusy   = busy;
      hz.VecDone   = done;
      // While VBUSY, E holds only bubbles, so branch/start inputs are meaningless.
      if (busy) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (hz.BranchTakenE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (hz.VecStartE || ldstall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  logic [15:0] stall_cnt, flush_cnt;
  logic        flush_br;

  assign flush_br = reset & ~busy & hz.BranchTakenE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, hz.StallD);
      flush_cnt <= sat_inc(flush_cnt, flush_br);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (VEC_LAT=4); counter checks under HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic sf, sd, fd, fe;
    logic [1:0] fa, fb;
    logic vb, vd;
  } obs_t;

  typedef struct packed {
    logic [2:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, mte, br, vs;
  } stim_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.RA_W(3)) hz();

  pipeline_hazard_ctrl #(.VEC_LAT(4), .RA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t tv[12];

  function automatic obs_t ob(input logic sf, sd, fd, fe, input logic [1:0] fa, fb,
                              input logic vb, vd);
    obs_t o;
    o.sf = sf; o.sd = sd; o.fd = fd; o.fe = fe;
    o.fa = fa; o.fb = fb; o.vb = vb; o.vd = vd;
    return o;
  endfunction

  function automatic stim_t st(input logic [2:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                               input logic rwe, rwm, rww, mte, br);
    stim_t s;
    s.ra1d = ra1d; s.ra2d = ra2d; s.ra1e = ra1e; s.ra2e = ra2e;
    s.wa3e = wa3e; s.wa3m = wa3m; s.wa3w = wa3w;
    s.rwe = rwe; s.rwm = rwm; s.rww = rww; s.mte = mte; s.br = br; s.vs = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic wm, input logic [2:0] am,
                                         input logic ww, input logic [2:0] aw,
                                         input logic [2:0] ra);
    if (wm && am == ra) return 2'b10;
    else if (ww && aw == ra) return 2'b01;
    else return 2'b00;
  endfunction

  // Reference for RUN-state cycles with no vector start.
  function automatic obs_t model(input stim_t s);
    obs_t o;
    logic ld;
    o  = '0;
    ld = s.mte & s.rwe & ((s.wa3e == s.ra1d) | (s.wa3e == s.ra2d));
    if (s.br) begin
      o.fd = 1'b1; o.fe = 1'b1;
    end else if (ld) begin
      o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
    end
    o.fa = fwd_ref(s.rwm, s.wa3m, s.rww, s.wa3w, s.ra1e);
    o.fb = fwd_ref(s.rwm, s.wa3m, s.rww, s.wa3w, s.ra2e);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.sf = hz.StallF; o.sd = hz.StallD; o.fd = hz.FlushD; o.fe = hz.FlushE;
    o.fa = hz.ForwardAE; o.fb = hz.ForwardBE; o.vb = hz.VecBusy; o.vd = hz.VecDone;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    hz.RA1D = s.ra1d; hz.RA2D = s.ra2d; hz.RA1E = s.ra1e; hz.RA2E = s.ra2e;
    hz.WA3E = s.wa3e; hz.WA3M = s.wa3m; hz.WA3W = s.wa3w;
    hz.RegWriteE = s.rwe; hz.RegWriteM = s.rwm; hz.RegWriteW = s.rww;
    hz.MemtoRegE = s.mte; hz.BranchTakenE = s.br; hz.VecStartE = s.vs;
  endtask

  task automatic check_obs(input string name);
    obs_t a, e;
    a = observe();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got=%b", name, a);
      return;
    end
    e = exp_q.pop_front();
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got {sf,sd,fd,fe,fa,fb,vb,vd}=%b want=%b", name, a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cycle(input stim_t s, input obs_t e, input string name);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
    check_obs(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    obs_t  z;
    logic  ld_hit;
    z = '0;

    tv[0]  = '{st(0,0,3,5,0,3,3, 0,1,1,0,0), ob(0,0,0,0,2'b10,2'b00,0,0)};
    tv[1]  = '{st(0,0,3,5,0,3,3, 0,0,1,0,0), ob(0,0,0,0,2'b01,2'b00,0,0)};
    tv[2]  = '{st(0,0,3,3,0,3,3, 0,1,1,0,0), ob(0,0,0,0,2'b10,2'b10,0,0)};
    tv[3]  = '{st(0,0,0,0,0,4,0, 0,0,1,0,0), ob(0,0,0,0,2'b01,2'b01,0,0)};
    tv[4]  = '{st(0,0,6,7,0,7,6, 0,1,1,0,0), ob(0,0,0,0,2'b01,2'b10,0,0)};
    tv[5]  = '{st(0,0,2,2,0,2,2, 0,0,0,0,0), ob(0,0,0,0,2'b00,2'b00,0,0)};
    tv[6]  = '{st(1,2,0,0,2,0,0, 1,0,0,1,0), ob(1,1,0,1,2'b00,2'b00,0,0)};
    tv[7]  = '{st(5,0,0,0,5,0,0, 1,0,0,1,0), ob(1,1,0,1,2'b00,2'b00,0,0)};
    tv[8]  = '{st(1,2,0,0,2,0,0, 0,0,0,1,0), ob(0,0,0,0,2'b00,2'b00,0,0)};
    tv[9]  = '{st(1,2,0,0,2,0,0, 1,0,0,0,0), ob(0,0,0,0,2'b00,2'b00,0,0)};
    tv[10] = '{st(4,0,0,0,4,0,0, 1,0,0,1,1), ob(0,0,1,1,2'b00,2'b00,0,0)};
    tv[11] = '{st(0,0,1,6,0,1,6, 0,1,1,0,1), ob(0,0,1,1,2'b10,2'b01,0,0)};

    // Reset held: outputs forced low even with active hazards on the inputs.
    s = st(2,2,0,0,2,0,0, 1,1,1,1,1);
    s.vs = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(z);
    check_obs("reset_state");
    drive('0);
    #1 reset = 1'b1;

    for (int i = 0; i < 12; i++) cycle(tv[i].s, tv[i].e, $sformatf("table_%0d", i));

    for (int i = 0; i < 40; i++) begin
      s = '0;
      s.ra1d = 3'($urandom_range(0, 3)); s.ra2d = 3'($urandom_range(0, 3));
      s.ra1e = 3'($urandom_range(0, 3)); s.ra2e = 3'($urandom_range(0, 3));
      s.wa3e = 3'($urandom_range(0, 3)); s.wa3m = 3'($urandom_range(0, 3));
      s.wa3w = 3'($urandom_range(0, 3));
      s.rwe = 1'($urandom); s.rwm = 1'($urandom); s.rww = 1'($urandom);
      s.mte = 1'($urandom); s.br = ($urandom_range(0, 3) == 0);
      cycle(s, model(s), $sformatf("rand_%0d", i));
    end

    // Load-use stall, then the load in M forwards to src2.
    cycle(st(0,2,0,0,2,0,0, 1,0,0,1,0), ob(1,1,0,1,2'b00,2'b00,0,0), "lu_stall");
    cycle(st(0,0,0,2,0,2,0, 0,1,0,0,0), ob(0,0,0,0,2'b00,2'b10,0,0), "lu_fwd_m");
    cycle('0, z, "lu_clear");

    // Vector op: start cycle plus three VBUSY cycles, done on the last.
    s = '0; s.vs = 1'b1;
    cycle(s, ob(1,1,0,1,2'b00,2'b00,0,0), "vec_c0");
    s = st(0,0,1,0,0,1,0, 0,1,0,0,0);
    cycle(s, ob(1,1,0,1,2'b10,2'b00,1,0), "vec_c1");
    s = '0; s.br = 1'b1; s.vs = 1'b1;
    cycle(s, ob(1,1,0,1,2'b00,2'b00,1,0), "vec_c2_ignore_br");
    cycle('0, ob(1,1,0,1,2'b00,2'b00,1,1), "vec_c3_done");
    cycle('0, z, "vec_c4_idle");
    cycle('0, z, "vec_c5_idle");

    // Branch beats both a load-use hazard and a vector start.
    s = st(0,2,0,0,2,0,0, 1,0,0,1,1); s.vs = 1'b1;
    cycle(s, ob(0,0,1,1,2'b00,2'b00,0,0), "br_over_hazard");
    cycle('0, z, "br_no_vbusy");

    // Asynchronous reset during VBUSY cycle 2.
    s = '0; s.vs = 1'b1;
    cycle(s, ob(1,1,0,1,2'b00,2'b00,0,0), "rst_op_c0");
    cycle('0, ob(1,1,0,1,2'b00,2'b00,1,0), "rst_op_c1");
    @(posedge clk);
    #1;
    s = st(0,0,3,0,0,3,0, 0,1,0,0,0);
    drive(s);
    exp_q.push_back(ob(1,1,0,1,2'b10,2'b00,1,0));
    #1 check_obs("rst_op_c2");
    #1 reset = 1'b0;
    #1 exp_q.push_back(z);
    check_obs("rst_async_low");
    drive('0);
    @(negedge clk);
    #1 reset = 1'b1;
    cycle('0, z, "rst_after_c0");
    cycle('0, z, "rst_after_c1");
    cycle('0, z, "rst_after_c2");

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("perf_stall_reset", hz.StallCnt, 16'h0000);
    check_val("perf_flush_reset", hz.FlushCnt, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(st(0,2,0,0,2,0,0, 1,0,0,1,0), ob(1,1,0,1,2'b00,2'b00,0,0), "perf_lu");
      cycle('0, z, "perf_lu_gap");
    end
    s = '0; s.vs = 1'b1;
    cycle(s, ob(1,1,0,1,2'b00,2'b00,0,0), "perf_vec_c0");
    cycle('0, ob(1,1,0,1,2'b00,2'b00,1,0), "perf_vec_c1");
    cycle('0, ob(1,1,0,1,2'b00,2'b00,1,0), "perf_vec_c2");
    cycle('0, ob(1,1,0,1,2'b00,2'b00,1,1), "perf_vec_c3");
    for (int i = 0; i < 2; i++) begin
      cycle(st(0,0,0,0,0,0,0, 0,0,0,0,1), ob(0,0,1,1,2'b00,2'b00,0,0), "perf_br");
      cycle('0, z, "perf_br_gap");
    end
    check_val("perf_stall_cnt", hz.StallCnt, 16'd7);
    check_val("perf_flush_cnt", hz.FlushCnt, 16'd2);
    @(posedge clk);
    #1 drive(st(0,2,0,0,2,0,0, 1,0,0,1,0));
    ld_hit = 1'b1;
    repeat (70000) @(posedge clk);
    #1 drive('0);
    @(negedge clk);
    check_val("perf_stall_sat", hz.StallCnt, 16'hFFFF);
    check_val("perf_flush_hold", hz.FlushCnt, 16'd2);
`else
    ld_hit = 1'b0;
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got=%0d leftover want=0 (ld_hit=%0b)", exp_q.size(), ld_hit);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
